// File: rtl/snn_pkg.sv
// Shared types and arithmetic helpers for the spiking-network layer engines and their sequencer.
package snn_pkg;

  localparam int W_W_DEF = 8;
  localparam int V_W_DEF = 12;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_ACC,
    S_FIRE,
    S_DONE
  } state_e;

  // Signed add clamped to the range of a v_w-bit two's-complement membrane.
  function automatic int sat_add(input int a, input int b, input int v_w);
    int sum;
    int hi;
    int lo;
    sum = a + b;
    hi  = (1 <<< (v_w - 1)) - 1;
    lo  = -(1 <<< (v_w - 1));
    if (sum > hi)      return hi;
    else if (sum < lo) return lo;
    else               return sum;
  endfunction

  // Multiplicative decay by (1 - 2^-shift); arithmetic shift keeps negative potentials negative.
  function automatic int leak(input int v, input int shift);
    if (shift == 0) return v;
    return v - (v >>> shift);
  endfunction

endpackage

// File: rtl/snn_lif_layer_vmem.sv
// Membrane register file: async read, single write port, synchronous clear-all.
module snn_vmem #(
  parameter int N_OUT = 2,
  parameter int V_W   = 12,
  parameter int JW    = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic [JW-1:0]         rd_idx_i,
  output logic signed [V_W-1:0] rd_data_o,
  input  logic                  we_i,
  input  logic [JW-1:0]         wr_idx_i,
  input  logic signed [V_W-1:0] wr_data_i
);

  logic signed [V_W-1:0] mem_q [N_OUT];

  assign rd_data_o = mem_q[rd_idx_i];

  // NOTE: this array is reset on purpose -- membranes must start from 0 and reset mid-run discards them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_OUT; k++) mem_q[k] <= '0;
    end else if (clr_i) begin
      for (int k = 0; k < N_OUT; k++) mem_q[k] <= '0;
    end else if (we_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/snn_lif_layer.sv
// Time-multiplexed LIF layer: per start pulse, leaks, integrates and fires each neuron in turn.
module snn_lif_layer
  import snn_pkg::*;
#(
  parameter int N_IN       = 4,
  parameter int N_OUT      = 2,
  parameter int W_W        = W_W_DEF,
  parameter int V_W        = V_W_DEF,
  parameter int THRESH     = 100,
  parameter int LEAK_SHIFT = 2,
  parameter int AW         = $clog2(N_IN * N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clr_v,
  input  logic [N_IN-1:0]  in_spk,
  output logic [AW-1:0]    w_addr,
  input  logic [W_W-1:0]   w_data,
  output logic [N_OUT-1:0] out_spk,
  output logic             busy,
  output logic             done
);

  localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int JW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

  state_e                state_q;
  logic [IW-1:0]         i_q;
  logic [JW-1:0]         j_q;
  logic signed [V_W-1:0] acc_q;
  logic [AW-1:0]         addr_q;
  logic [N_OUT-1:0]      spk_q;
  logic                  busy_q;
  logic                  done_q;

  logic signed [V_W-1:0] v_rd;
  logic signed [V_W-1:0] leak_d;
  logic signed [V_W-1:0] sum_d;
  logic signed [V_W-1:0] v_wr_d;
  logic [AW-1:0]         next_base_d;
  logic                  fire_d;
  logic                  v_we;
  logic                  v_clr;

  assign w_addr  = addr_q;
  assign out_spk = spk_q;
  assign busy    = busy_q;
  assign done    = done_q;

  assign v_we  = (state_q == S_FIRE);
  assign v_clr = (state_q == S_IDLE) && clr_v;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    leak_d      = V_W'(leak(int'(v_rd), LEAK_SHIFT));
    sum_d       = V_W'(sat_add(int'(acc_q), int'($signed(w_data)), V_W));
    fire_d      = (int'(acc_q) >= THRESH);
    v_wr_d      = fire_d ? '0 : acc_q;
    next_base_d = AW'((int'(j_q) + 1) * N_IN);
  end

  snn_vmem #(
    .N_OUT (N_OUT),
    .V_W   (V_W),
    .JW    (JW)
  ) u_vmem (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (v_clr),
    .rd_idx_i  (j_q),
    .rd_data_o (v_rd),
    .we_i      (v_we),
    .wr_idx_i  (j_q),
    .wr_data_i (v_wr_d)
  );

  // w_addr runs one index ahead of the weight being accumulated to hide the ROM latency.
  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      acc_q   <= '0;
      addr_q  <= '0;
      spk_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_LOAD;
            j_q     <= '0;
            addr_q  <= '0;
            spk_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_LOAD: begin
          acc_q   <= leak_d;
          i_q     <= '0;
          addr_q  <= addr_q + AW'(1);
          state_q <= S_ACC;
        end
        S_ACC: begin
          if (in_spk[i_q]) acc_q <= sum_d;
          if (i_q == IW'(N_IN - 1)) begin
            state_q <= S_FIRE;
          end else begin
            i_q    <= i_q + IW'(1);
            addr_q <= addr_q + AW'(1);
          end
        end
        S_FIRE: begin
          spk_q[j_q] <= fire_d;
          if (j_q == JW'(N_OUT - 1)) begin
            addr_q  <= '0;
            state_q <= S_DONE;
          end else begin
            j_q     <= j_q + JW'(1);
            addr_q  <= next_base_d;
            state_q <= S_LOAD;
          end
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_lif_layer.sv
// Directed bench: a default layer (A) and an 8-bit-membrane layer (B) driven with the same stimulus.
module tb_snn_lif_layer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       clr_v;
  logic [3:0] in_spk;
  logic [2:0] wa_a, wa_b;
  logic [7:0] wd_a, wd_b;
  logic [1:0] spk_a, spk_b;
  logic       busy_a, busy_b, done_a, done_b;

  logic signed [7:0] rom [8];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    wd_a <= rom[wa_a];
    wd_b <= rom[wa_b];
  end

  snn_lif_layer dut_a (
    .clk (clk), .rst_n (rst_n), .start (start), .clr_v (clr_v), .in_spk (in_spk),
    .w_addr (wa_a), .w_data (wd_a), .out_spk (spk_a), .busy (busy_a), .done (done_a)
  );

  snn_lif_layer #(.V_W(8)) dut_b (
    .clk (clk), .rst_n (rst_n), .start (start), .clr_v (clr_v), .in_spk (in_spk),
    .w_addr (wa_b), .w_data (wd_b), .out_spk (spk_b), .busy (busy_b), .done (done_b)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  task automatic set_rom(input int w0, input int w1, input int w2, input int w3,
                         input int w4, input int w5, input int w6, input int w7);
    rom[0] = 8'(w0); rom[1] = 8'(w1); rom[2] = 8'(w2); rom[3] = 8'(w3);
    rom[4] = 8'(w4); rom[5] = 8'(w5); rom[6] = 8'(w6); rom[7] = 8'(w7);
  endtask

  // One timestep run; poke pulses start and clr_v together during neuron 0 ACC.
  task automatic run(input string tag, input logic [3:0] spk, input bit clr, input bit poke,
                     input bit chk_a, input logic [1:0] exp_a,
                     input bit chk_b, input logic [1:0] exp_b);
    int lat;
    @(negedge clk);
    in_spk = spk;
    start  = 1'b1;
    clr_v  = clr;
    @(negedge clk);
    start = 1'b0;
    clr_v = 1'b0;
    check({tag, ".busy_hi"}, busy_a, 1);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      @(negedge clk);
      if (done_a) lat = k;
      start = poke && (k == 3);
      clr_v = poke && (k == 3);
    end
    start = 1'b0;
    clr_v = 1'b0;
    check({tag, ".latency"}, lat, 13);
    check({tag, ".done_b"}, done_b, 1);
    check({tag, ".busy_lo"}, busy_a, 0);
    if (chk_a) check({tag, ".spk_a"}, spk_a, exp_a);
    if (chk_b) check({tag, ".spk_b"}, spk_b, exp_b);
    @(negedge clk);
    check({tag, ".done_pulse"}, done_a, 0);
    if (chk_a) check({tag, ".spk_a_held"}, spk_a, exp_a);
  endtask

  initial begin
    int seen;
    rst_n  = 1'b0;
    start  = 1'b0;
    clr_v  = 1'b0;
    in_spk = 4'b0;
    set_rom(40, 30, 50, 20, 60, 10, -5, 50);

    repeat (4) begin
      @(negedge clk);
      start  = 1'($urandom);
      clr_v  = 1'($urandom);
      in_spk = 4'($urandom);
    end
    check("rst.spk_a", spk_a, 0);
    check("rst.done_a", done_a, 0);
    check("rst.busy_a", busy_a, 0);
    check("rst.addr_a", wa_a, 0);
    check("rst.spk_b", spk_b, 0);
    check("rst.busy_b", busy_b, 0);
    start = 1'b0;
    clr_v = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // v0 = 90 (no spike), v1 = 120 (spike)
    run("single", 4'b1011, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00);
    // v0 = 68 + 90 = 158, v1 = 0 + 120
    run("leak", 4'b1011, 1'b0, 1'b0, 1'b1, 2'b11, 1'b0, 2'b00);

    @(negedge clk);
    clr_v = 1'b1;
    @(negedge clk);
    clr_v = 1'b0;
    run("clr_idle", 4'b1011, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00);

    run("poke", 4'b1011, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 2'b00);

    // Reset during neuron 1 ACC.
    @(negedge clk);
    in_spk = 4'b1011;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("midrst.busy_before", busy_a, 1);
    rst_n = 1'b0;
    #1;
    check("midrst.spk", spk_a, 0);
    check("midrst.busy", busy_a, 0);
    check("midrst.done", done_a, 0);
    check("midrst.addr", wa_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done_a) seen++;
    end
    check("midrst.no_done", seen, 0);
    run("fresh", 4'b1011, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00);

    // start with clr_v: from-zero result despite v0 = 90 held.
    run("clr_start", 4'b1011, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 2'b00);

    // Saturation: B clamps at 127 and spikes; a wrapping adder would not.
    set_rom(127, 127, 127, 127, 127, 127, 127, 127);
    run("sat_pos", 4'hF, 1'b1, 1'b0, 1'b1, 2'b11, 1'b1, 2'b11);
    // B clamps to -128; A reaches -512.
    set_rom(-128, -128, -128, -128, -128, -128, -128, -128);
    run("sat_neg", 4'hF, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b00);
    // B: -96 + 196 = 100 hits threshold exactly; A: -384 + 196 = -188.
    set_rom(49, 49, 49, 49, 49, 49, 49, 49);
    run("neg_leak", 4'hF, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 2'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

endmodule
